// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder with carry-in. Adds one CHUNK-bit
// slice per clock, least-significant slice first, rippling the carry between
// cycles. Start/Busy/Done handshake; Sum and Carry are registered and update
// only on the cycle the operation completes.
// Optional feature macro: ACCUMULATE_EN adds the Acc input, which selects the
// current Sum register as the B operand when a new operation is accepted.
module chunked_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef ACCUMULATE_EN
   input  logic             Acc,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // A slice width that does not tile the operand would leave bits unprocessed.
   generate
      if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
         $error("chunked_adder: CHUNK must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic             c_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;

   int               slice_base_s;
   logic [CHUNK-1:0] a_slice_s;
   logic [CHUNK-1:0] b_slice_s;
   logic [CHUNK:0]   slice_s;
   logic [WIDTH-1:0] res_next_s;
   logic [WIDTH-1:0] b_sel_s;
   logic             accept_s;

   // One CHUNK-bit ripple: {carry_out, sum} = x + y + ci.
   function automatic logic [CHUNK:0] slice_add(
      input logic [CHUNK-1:0] x,
      input logic [CHUNK-1:0] y,
      input logic             ci
   );
      return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
   endfunction

   // Slice selection, slice addition and merge of the slice into the result.
   always_comb begin
      slice_base_s = int'(cnt_r) * CHUNK;
      a_slice_s    = a_r[slice_base_s +: CHUNK];
      b_slice_s    = b_r[slice_base_s +: CHUNK];
      slice_s      = slice_add(a_slice_s, b_slice_s, c_r);
      res_next_s   = res_r;
      res_next_s[slice_base_s +: CHUNK] = slice_s[CHUNK-1:0];
   end

   // New operation may start from IDLE or straight out of DONE; B may come from Sum.
   always_comb begin
      accept_s = Start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
`ifdef ACCUMULATE_EN
      if (Acc) begin
         b_sel_s = Sum;
      end else begin
         b_sel_s = B;
      end
`else
      b_sel_s = B;
`endif
   end

   // Control FSM and datapath registers; Busy/Done are registered from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         c_r     <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         Sum     <= '0;
         Carry   <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (accept_s) begin
                  a_r     <= A;
                  b_r     <= b_sel_s;
                  c_r     <= Cin;
                  cnt_r   <= '0;
                  res_r   <= '0;
                  state_r <= ST_RUN;
                  Busy    <= 1'b1;
                  Done    <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
                  Busy    <= 1'b0;
                  Done    <= 1'b0;
               end
            end
            ST_RUN: begin
               res_r <= res_next_s;
               c_r   <= slice_s[CHUNK];
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= '0;
                  Sum     <= res_next_s;
                  Carry   <= slice_s[CHUNK];
                  state_r <= ST_DONE;
                  Busy    <= 1'b0;
                  Done    <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
                  state_r <= ST_RUN;
                  Busy    <= 1'b1;
                  Done    <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               Busy    <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
